dq_write_sequencer: RTL and testbench

- Upstream of the per-pin 4:1 DDR output serializers in the DDR3 PHY; runs in the clk_div domain.
- Accepts BL8 write bursts: one command carries all 8 beats of data and mask.
- Produces per-pin 4-bit parallel data and tristate nibbles for DQ, DM and DQS.
- Handles write latency, DQS preamble/postamble, tristate control and seamless back-to-back bursts.

---
 rtl/dq_wseq_pkg.sv | 19 +
 rtl/wseq_delay_line.sv | 54 +++++
 rtl/dq_write_sequencer.sv | 165 ++++++++++++++++
 tb/tb_dq_write_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dq_wseq_pkg.sv
// Shared constants and slot encoding for the DQ write sequencer.
// Nibble constants are in serializer order: bit 0 goes out on the wire first.
package dq_wseq_pkg;

   localparam logic [3:0] DQS_PRE    = 4'b0000;
   localparam logic [3:0] DQS_TOGGLE = 4'b1010;
   localparam logic [3:0] DQS_POST_T = 4'b1100;
   localparam logic [3:0] TRI_ON     = 4'b1111;
   localparam logic [3:0] TRI_OFF    = 4'b0000;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      DATA_A,
      DATA_B,
      POST
   } slot_e;

endpackage

// File: rtl/wseq_delay_line.sv
// Age-indexed delay line for accepted write bursts.
// Stage s holds the burst accepted s+1 edges ago; only the valid bits travel the full depth.
module wseq_delay_line #(
   parameter int DQ_WIDTH = 8,
   parameter int DEPTH    = 5,
   parameter int TAP      = 2
) (
   input  logic                  clk_div,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic [8*DQ_WIDTH-1:0] data_i,
   input  logic [7:0]            mask_i,
   output logic [DEPTH-1:0]      valid_o,
   output logic [8*DQ_WIDTH-1:0] tap_data_o,
   output logic [7:0]            tap_mask_o,
   output logic [8*DQ_WIDTH-1:0] next_data_o,
   output logic [7:0]            next_mask_o
);

   localparam int DATA_DEPTH = TAP + 2;

   logic [DEPTH-1:0]      validQ;
   logic [8*DQ_WIDTH-1:0] dataQ [DATA_DEPTH];
   logic [7:0]            maskQ [DATA_DEPTH];

   // Valid bits shift through every stage so the top level can see the
   // preamble, both data slots and the postamble. Payload is only needed up to
   // the second data tap, so the payload chain stops there. Payload is captured
   // every cycle; a stage without its valid bit is simply ignored downstream.
   always_ff @(posedge clk_div or negedge rst_n) begin
      if (!rst_n) begin
         validQ <= '0;
         for (int s = 0; s < DATA_DEPTH; s++) begin
            dataQ[s] <= '0;
            maskQ[s] <= '0;
         end
      end else begin
         validQ   <= {validQ[DEPTH-2:0], push_i};
         dataQ[0] <= data_i;
         maskQ[0] <= mask_i;
         for (int s = 1; s < DATA_DEPTH; s++) begin
            dataQ[s] <= dataQ[s-1];
            maskQ[s] <= maskQ[s-1];
         end
      end
   end

   assign valid_o     = validQ;
   assign tap_data_o  = dataQ[TAP];
   assign tap_mask_o  = maskQ[TAP];
   assign next_data_o = dataQ[TAP+1];
   assign next_mask_o = maskQ[TAP+1];

endmodule

// File: rtl/dq_write_sequencer.sv
// BL8 write sequencer feeding the 4:1 DQ/DM/DQS output serializers of one byte lane.
// Turns one accepted command into preamble, two data slots and a postamble after WLAT cycles.
module dq_write_sequencer
   import dq_wseq_pkg::*;
#(
   parameter int DQ_WIDTH = 8,
   parameter int WLAT     = 2
) (
   input  logic                  clk_div,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [8*DQ_WIDTH-1:0] wr_data,
   input  logic [7:0]            wr_mask,
   output logic [4*DQ_WIDTH-1:0] dq_din,
   output logic [4*DQ_WIDTH-1:0] dq_tin,
   output logic [3:0]            dm_din,
   output logic [3:0]            dm_tin,
   output logic [3:0]            dqs_din,
   output logic [3:0]            dqs_tin,
   output logic                  busy
);

   localparam int DEPTH   = WLAT + 3;
   localparam int BURST_W = 8 * DQ_WIDTH;
   localparam int HALF_W  = 4 * DQ_WIDTH;

   logic               cmdReadyQ;
   logic               busyQ;
   logic               accept;
   logic [DEPTH-1:0]   stageValid;
   logic [BURST_W-1:0] tapAData;
   logic [BURST_W-1:0] tapBData;
   logic [7:0]         tapAMask;
   logic [7:0]         tapBMask;
   slot_e              slot;
   logic [BURST_W-1:0] burstData;
   logic [7:0]         burstMask;
   logic [HALF_W-1:0]  halfData;
   logic [3:0]         halfMask;

   logic [HALF_W-1:0]  dqDinD, dqDinQ;
   logic [HALF_W-1:0]  dqTinD, dqTinQ;
   logic [3:0]         dmDinD, dmDinQ;
   logic [3:0]         dmTinD, dmTinQ;
   logic [3:0]         dqsDinD, dqsDinQ;
   logic [3:0]         dqsTinD, dqsTinQ;

   assign accept = cmd_valid & cmdReadyQ;

   wseq_delay_line #(
      .DQ_WIDTH (DQ_WIDTH),
      .DEPTH    (DEPTH),
      .TAP      (WLAT)
   ) delayLine (
      .clk_div     (clk_div),
      .rst_n       (rst_n),
      .push_i      (accept),
      .data_i      (wr_data),
      .mask_i      (wr_mask),
      .valid_o     (stageValid),
      .tap_data_o  (tapAData),
      .tap_mask_o  (tapAMask),
      .next_data_o (tapBData),
      .next_mask_o (tapBMask)
   );

   // Pick the slot for the next registered output. A burst sitting in stage
   // WLAT-1 becomes the preamble on the coming edge, WLAT the first data half,
   // WLAT+1 the second, WLAT+2 the postamble. Data beats any framing slot so
   // back-to-back bursts stream seamlessly, and a new preamble overrides an
   // older postamble so DQS stays driven low through a one-cycle gap.
   always_comb begin
      slot = IDLE;
      if (stageValid[WLAT]) begin
         slot = DATA_A;
      end else if (stageValid[WLAT+1]) begin
         slot = DATA_B;
      end else if (stageValid[WLAT-1]) begin
         slot = PRE;
      end else if (stageValid[WLAT+2]) begin
         slot = POST;
      end
   end

   // Select the four beats (and their mask bits) that belong to the current
   // data slot: beats 0..3 from the first tap, beats 4..7 from the second.
   always_comb begin
      burstData = stageValid[WLAT] ? tapAData : tapBData;
      burstMask = stageValid[WLAT] ? tapAMask : tapBMask;
      halfData  = (slot == DATA_A) ? burstData[HALF_W-1:0] : burstData[BURST_W-1:HALF_W];
      halfMask  = (slot == DATA_A) ? burstMask[3:0] : burstMask[7:4];
   end

   // Build the next serializer nibbles. Everything defaults to idle (all pins
   // tristated, DQS low), then each slot only overrides what it drives. In a
   // data slot, bit j of pin i's nibble is bit i of beat j, so beat 0 leaves
   // the serializer first.
   always_comb begin
      dqDinD  = '0;
      dqTinD  = '1;
      dmDinD  = 4'b0000;
      dmTinD  = TRI_ON;
      dqsDinD = DQS_PRE;
      dqsTinD = TRI_ON;
      case (slot)
         PRE: begin
            dqsTinD = TRI_OFF;
         end
         DATA_A, DATA_B: begin
            for (int i = 0; i < DQ_WIDTH; i++) begin
               for (int j = 0; j < 4; j++) begin
                  dqDinD[4*i+j] = halfData[DQ_WIDTH*j+i];
               end
            end
            dqTinD  = '0;
            dmDinD  = halfMask;
            dmTinD  = TRI_OFF;
            dqsDinD = DQS_TOGGLE;
            dqsTinD = TRI_OFF;
         end
         POST: begin
            dqsTinD = DQS_POST_T;
         end
         default: begin
         end
      endcase
   end

   // All outputs are registered. Reset idles the pins immediately and holds
   // cmd_ready low; after a command is taken, cmd_ready drops for one cycle
   // because a BL8 burst occupies two clk_div cycles. busy covers the window
   // from acceptance through the cycle showing that burst's postamble.
   always_ff @(posedge clk_div or negedge rst_n) begin
      if (!rst_n) begin
         cmdReadyQ <= 1'b0;
         busyQ     <= 1'b0;
         dqDinQ    <= '0;
         dqTinQ    <= '1;
         dmDinQ    <= 4'b0000;
         dmTinQ    <= TRI_ON;
         dqsDinQ   <= DQS_PRE;
         dqsTinQ   <= TRI_ON;
      end else begin
         cmdReadyQ <= ~accept;
         busyQ     <= accept | (|stageValid);
         dqDinQ    <= dqDinD;
         dqTinQ    <= dqTinD;
         dmDinQ    <= dmDinD;
         dmTinQ    <= dmTinD;
         dqsDinQ   <= dqsDinD;
         dqsTinQ   <= dqsTinD;
      end
   end

   assign cmd_ready = cmdReadyQ;
   assign busy      = busyQ;
   assign dq_din    = dqDinQ;
   assign dq_tin    = dqTinQ;
   assign dm_din    = dmDinQ;
   assign dm_tin    = dmTinQ;
   assign dqs_din   = dqsDinQ;
   assign dqs_tin   = dqsTinQ;

endmodule

// File: tb/tb_dq_write_sequencer.sv
// Self-checking bench for dq_write_sequencer: directed scenarios plus random traffic,
// compared each cycle against a burst-list model that derives slots from burst age.
module tb_dq_write_sequencer;

   localparam int DQ_WIDTH = 8;
   localparam int WLAT     = 2;

   logic                  clk_div = 1'b0;
   logic                  rst_n;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [8*DQ_WIDTH-1:0] wr_data;
   logic [7:0]            wr_mask;
   logic [4*DQ_WIDTH-1:0] dq_din;
   logic [4*DQ_WIDTH-1:0] dq_tin;
   logic [3:0]            dm_din;
   logic [3:0]            dm_tin;
   logic [3:0]            dqs_din;
   logic [3:0]            dqs_tin;
   logic                  busy;

   typedef struct {
      int                    accEdge;
      logic [8*DQ_WIDTH-1:0] data;
      logic [7:0]            mask;
   } burst_t;

   burst_t bursts[$];
   int     edgeCount   = 0;
   int     releaseEdge = 0;
   bit     inReset     = 1'b1;
   int     testsRun    = 0;
   int     failCount   = 0;

   dq_write_sequencer #(
      .DQ_WIDTH (DQ_WIDTH),
      .WLAT     (WLAT)
   ) dut (
      .clk_div   (clk_div),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .wr_data   (wr_data),
      .wr_mask   (wr_mask),
      .dq_din    (dq_din),
      .dq_tin    (dq_tin),
      .dm_din    (dm_din),
      .dm_tin    (dm_tin),
      .dqs_din   (dqs_din),
      .dqs_tin   (dqs_tin),
      .busy      (busy)
   );

   // Free-running divided clock.
   always #5 clk_div = ~clk_div;

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic bit modelReady();
      if (inReset || edgeCount <= releaseEdge) return 1'b0;
      foreach (bursts[k]) begin
         if (bursts[k].accEdge == edgeCount) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testsRun++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, edgeCount);
      end
   endtask

   // Compare every output with the model. A burst accepted at edge N shows its
   // preamble after edge N+WLAT, data halves at +1/+2 and postamble at +3.
   task automatic checkAll();
      logic [4*DQ_WIDTH-1:0] expDq, expDqT;
      logic [3:0]            expDm, expDmT, expDqs, expDqsT;
      logic [8*DQ_WIDTH-1:0] srcData;
      logic [7:0]            srcMask;
      bit                    expBusy, hasData, hasPre, hasPost;
      int                    age, base;
      expDq   = '0;
      expDqT  = '1;
      expDm   = 4'b0000;
      expDmT  = 4'b1111;
      expDqs  = 4'b0000;
      expDqsT = 4'b1111;
      expBusy = 1'b0;
      hasData = 1'b0;
      hasPre  = 1'b0;
      hasPost = 1'b0;
      base    = 0;
      srcData = '0;
      srcMask = '0;
      foreach (bursts[k]) begin
         age = edgeCount - bursts[k].accEdge;
         if (age >= 0 && age <= WLAT + 3) expBusy = 1'b1;
         if (age == WLAT + 1 || age == WLAT + 2) begin
            hasData = 1'b1;
            base    = (age == WLAT + 1) ? 0 : 4;
            srcData = bursts[k].data;
            srcMask = bursts[k].mask;
         end
         if (age == WLAT) hasPre = 1'b1;
         if (age == WLAT + 3) hasPost = 1'b1;
      end
      if (hasData) begin
         for (int i = 0; i < DQ_WIDTH; i++) begin
            for (int j = 0; j < 4; j++) begin
               expDq[4*i+j] = srcData[DQ_WIDTH*(base+j)+i];
            end
         end
         for (int j = 0; j < 4; j++) expDm[j] = srcMask[base+j];
         expDqT  = '0;
         expDmT  = 4'b0000;
         expDqs  = 4'b1010;
         expDqsT = 4'b0000;
      end else if (hasPre) begin
         expDqsT = 4'b0000;
      end else if (hasPost) begin
         expDqsT = 4'b1100;
      end
      checkOutput("cmd_ready", 64'(cmd_ready), 64'(modelReady()));
      checkOutput("busy",      64'(busy),      64'(expBusy));
      checkOutput("dq_din",    64'(dq_din),    64'(expDq));
      checkOutput("dq_tin",    64'(dq_tin),    64'(expDqT));
      checkOutput("dm_din",    64'(dm_din),    64'(expDm));
      checkOutput("dm_tin",    64'(dm_tin),    64'(expDmT));
      checkOutput("dqs_din",   64'(dqs_din),   64'(expDqs));
      checkOutput("dqs_tin",   64'(dqs_tin),   64'(expDqsT));
      while (bursts.size() > 0 && edgeCount - bursts[0].accEdge > WLAT + 3) begin
         void'(bursts.pop_front());
      end
   endtask

   // Drive one cycle of inputs from the falling edge, clock it, record any
   // acceptance the model predicts, then check on the next falling edge.
   task automatic applyStimulus(input bit v, input logic [63:0] d, input logic [7:0] m);
      bit     acc;
      burst_t b;
      cmd_valid = v;
      wr_data   = d;
      wr_mask   = m;
      acc       = v && modelReady();
      @(posedge clk_div);
      edgeCount++;
      if (acc) begin
         b.accEdge = edgeCount;
         b.data    = d;
         b.mask    = m;
         bursts.push_back(b);
      end
      @(negedge clk_div);
      checkAll();
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 64'h0, 8'h00);
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      wr_data   = '0;
      wr_mask   = '0;

      // Reset held for three cycles, then released away from the clock edge.
      @(negedge clk_div);
      checkAll();
      idleCycles(3);
      rst_n       = 1'b1;
      inReset     = 1'b0;
      releaseEdge = edgeCount;
      #1;
      checkAll();
      idleCycles(1);
      checkOutput("ready_after_reset", 64'(cmd_ready), 64'd1);

      // Single burst, beats 0x01..0x08, no mask.
      applyStimulus(1'b1, 64'h0807060504030201, 8'h00);
      checkOutput("ready_drop", 64'(cmd_ready), 64'd0);
      checkOutput("busy_start", 64'(busy), 64'd1);
      idleCycles(2);
      checkOutput("pre_dqs_din", 64'(dqs_din), 64'h0);
      checkOutput("pre_dqs_tin", 64'(dqs_tin), 64'h0);
      idleCycles(1);
      checkOutput("a_dqs_din", 64'(dqs_din), 64'hA);
      checkOutput("a_pin0", 64'(dq_din[3:0]), 64'h5);
      idleCycles(1);
      checkOutput("b_pin0", 64'(dq_din[3:0]), 64'h5);
      checkOutput("b_pin1", 64'(dq_din[7:4]), 64'h6);
      idleCycles(1);
      checkOutput("post_dqs_tin", 64'(dqs_tin), 64'hC);
      idleCycles(1);
      checkOutput("idle_dqs_tin", 64'(dqs_tin), 64'hF);
      checkOutput("idle_busy", 64'(busy), 64'd0);
      idleCycles(2);

      // Spacing 2, with a rejected request in between.
      applyStimulus(1'b1, 64'h1111_2222_3333_4444, 8'h0F);
      applyStimulus(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
      applyStimulus(1'b1, 64'h5555_6666_7777_8888, 8'hF0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 64'h0, 8'h00);
         checkOutput("seamless_dqs_din", 64'(dqs_din), 64'hA);
         checkOutput("seamless_dqs_tin", 64'(dqs_tin), 64'h0);
      end
      idleCycles(4);

      // Spacing 3; the second burst also carries mask 0xA5.
      applyStimulus(1'b1, {$urandom(), $urandom()}, 8'h00);
      idleCycles(2);
      applyStimulus(1'b1, {$urandom(), $urandom()}, 8'hA5);
      idleCycles(2);
      checkOutput("gap_dqs_din", 64'(dqs_din), 64'h0);
      checkOutput("gap_dqs_tin", 64'(dqs_tin), 64'h0);
      checkOutput("gap_dq_tin", 64'(dq_tin), 64'hFFFF_FFFF);
      idleCycles(1);
      checkOutput("mask_a_dm", 64'(dm_din), 64'h5);
      checkOutput("mask_a_tin", 64'(dm_tin), 64'h0);
      idleCycles(1);
      checkOutput("mask_b_dm", 64'(dm_din), 64'hA);
      checkOutput("mask_b_tin", 64'(dm_tin), 64'h0);
      idleCycles(3);

      // Random traffic at mixed spacings.
      for (int k = 0; k < 250; k++) begin
         applyStimulus(($urandom_range(0, 2) != 0), {$urandom(), $urandom()}, 8'($urandom()));
      end
      idleCycles(6);

      // Reset asserted while the first data half is on the pins.
      applyStimulus(1'b1, {$urandom(), $urandom()}, 8'($urandom()));
      idleCycles(3);
      checkOutput("pre_reset_dqs", 64'(dqs_din), 64'hA);
      rst_n   = 1'b0;
      inReset = 1'b1;
      bursts.delete();
      #1;
      checkOutput("midrst_dq_tin", 64'(dq_tin), 64'hFFFF_FFFF);
      checkOutput("midrst_dqs_tin", 64'(dqs_tin), 64'hF);
      checkOutput("midrst_dm_tin", 64'(dm_tin), 64'hF);
      checkAll();
      @(negedge clk_div);
      idleCycles(2);
      rst_n       = 1'b1;
      inReset     = 1'b0;
      releaseEdge = edgeCount;
      idleCycles(8);
      checkOutput("post_reset_busy", 64'(busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
